// File: rtl/bkm_csd_pkg.sv
// Shared constants for the bkm_steps stimulus driver: CSD digit codes and
// the driver FSM state encoding.
package bkm_csd_pkg;

  // Two bits per CSD digit; 2'b10 is never produced.
  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_NEG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV_X  = 2'd1,
    CONV_Y  = 2'd2,
    PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/bkm_steps_driver_if.sv
// Operand bus of the bkm_steps driver: binary operand set in, CSD operand
// set out.
//
// Handshake: a set moves on a rising clock edge where valid and ready are
// both high (and the driver's enable is high). The source holds valid and
// its data stable until that edge; the sink may raise or drop ready freely.
// in_valid/in_ready cover the binary side, out_valid/out_ready the CSD side.
interface bkm_steps_driver_if #(
  parameter int WD = 72,
  parameter int WC = 21
);
  logic              in_valid;
  logic              in_ready;
  logic [WD-1:0]     X_in_bin;
  logic [WD-1:0]     Y_in_bin;
  logic [WC-1:0]     u_in_bin;
  logic [WC-1:0]     v_in_bin;
  logic              out_valid;
  logic              out_ready;
  logic [2*WD-1:0]   X_in_csd;
  logic [2*WD-1:0]   Y_in_csd;
  logic [WC-1:0]     u_out_bin;
  logic [WC-1:0]     v_out_bin;

  // Sequencer / downstream-DUT side.
  modport master (
    output in_valid, X_in_bin, Y_in_bin, u_in_bin, v_in_bin, out_ready,
    input  in_ready, out_valid, X_in_csd, Y_in_csd, u_out_bin, v_out_bin
  );

  // Driver side.
  modport slave (
    input  in_valid, X_in_bin, Y_in_bin, u_in_bin, v_in_bin, out_ready,
    output in_ready, out_valid, X_in_csd, Y_in_csd, u_out_bin, v_out_bin
  );
endinterface

// File: rtl/bin2csd_slice.sv
// Combinational recoder for DPC consecutive bits of a two's-complement word
// into CSD digits, LSB first. bits[DPC] is the lookahead bit for the top
// digit of the slice; carry ripples from digit 0 upward.
module bin2csd_slice
  import bkm_csd_pkg::*;
#(
  parameter int DPC = 8
) (
  input  logic [DPC:0]     bits,
  input  logic             carry_in,
  output logic [2*DPC-1:0] digits,
  output logic             carry_out
);

  logic c;

  // Ripple the recoding rule across the slice: s = x_i + c, lookahead x_{i+1}.
  always_comb begin
    digits = '0;
    c      = carry_in;
    for (int j = 0; j < DPC; j++) begin
      if (bits[j] == c) begin
        // s == 0 or s == 2: zero digit, carry becomes x_i (0 or 1)
        digits[2*j +: 2] = CSD_ZERO;
        c                = bits[j];
      end else if (bits[j+1]) begin
        // s == 1 inside a run of ones: emit -1 and push the carry up
        digits[2*j +: 2] = CSD_NEG;
        c                = 1'b1;
      end else begin
        digits[2*j +: 2] = CSD_POS;
        c                = 1'b0;
      end
    end
    carry_out = c;
  end

endmodule

// File: rtl/bkm_steps_driver.sv
// Stimulus driver for bkm_steps: accepts binary X, Y, u, v, recodes X then Y
// into CSD with one shared digit-serial slice (DPC digits per enabled cycle),
// then presents the full set until the DUT consumes it.
module bkm_steps_driver
  import bkm_csd_pkg::*;
#(
  parameter int WD  = 72,
  parameter int WC  = 21,
  parameter int DPC = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 srst,
  input  logic                 enable,
  bkm_steps_driver_if.slave    bus,
  output logic [1:0]           state_dbg
);

  localparam int NCYC = WD / DPC;
  localparam int CW   = $clog2(NCYC + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic [WD:0]     work_q;      // operand being recoded, sign-extended by one bit
  logic [WD-1:0]   y_bin_q;
  logic [WC-1:0]   u_q, v_q;
  logic [2*WD-1:0] acc_q;       // digits shift in from the top, LSB digit first
  logic [2*WD-1:0] x_csd_q;     // finished X, parked while Y is recoded
  logic [2*WD-1:0] x_out_q, y_out_q;
  logic [WC-1:0]   u_out_q, v_out_q;

  logic [2*DPC-1:0] slice_digits;
  logic             slice_carry;
  logic [2*WD-1:0]  acc_next;
  logic [WD:0]      work_shift;
  logic             last_cyc;
  logic             accept;
  logic             out_xfer;
  logic             in_ready_c;
  logic             out_valid_c;

  bin2csd_slice #(.DPC(DPC)) u_slice (
    .bits      (work_q[DPC:0]),
    .carry_in  (carry_q),
    .digits    (slice_digits),
    .carry_out (slice_carry)
  );

  // Arithmetic shift keeps the lookahead of the top digit equal to the sign bit.
  assign work_shift = {{DPC{work_q[WD]}}, work_q[WD:DPC]};
  assign acc_next   = {slice_digits, acc_q[2*WD-1:2*DPC]};
  assign last_cyc   = (cnt_q == CW'(NCYC - 1));
  assign accept     = bus.in_valid & in_ready_c & enable;
  assign out_xfer   = bus.out_ready & out_valid_c & enable;

  // State register; both resets return to IDLE.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)     state_q <= IDLE;
    else if (srst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state: each conversion phase lasts NCYC enabled cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)             state_d = CONV_X;
      CONV_X:  if (enable && last_cyc) state_d = CONV_Y;
      CONV_Y:  if (enable && last_cyc) state_d = PRESENT;
      PRESENT: if (out_xfer)           state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so they hold while enable is low.
  always_comb begin
    in_ready_c  = (state_q == IDLE);
    out_valid_c = (state_q == PRESENT);
  end

  // Datapath: latch operands, run the shared slice, publish on entry to PRESENT.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst || srst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      y_bin_q <= '0;
      u_q     <= '0;
      v_q     <= '0;
      acc_q   <= '0;
      x_csd_q <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      u_out_q <= '0;
      v_out_q <= '0;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_q  <= {bus.X_in_bin[WD-1], bus.X_in_bin};
            y_bin_q <= bus.Y_in_bin;
            u_q     <= bus.u_in_bin;
            v_q     <= bus.v_in_bin;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        CONV_X: begin
          acc_q <= acc_next;
          if (last_cyc) begin
            x_csd_q <= acc_next;
            work_q  <= {y_bin_q[WD-1], y_bin_q};
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            work_q  <= work_shift;
            carry_q <= slice_carry;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        CONV_Y: begin
          acc_q <= acc_next;
          if (last_cyc) begin
            x_out_q <= x_csd_q;
            y_out_q <= acc_next;
            u_out_q <= u_q;
            v_out_q <= v_q;
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            work_q  <= work_shift;
            carry_q <= slice_carry;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.X_in_csd  = x_out_q;
  assign bus.Y_in_csd  = y_out_q;
  assign bus.u_out_bin = u_out_q;
  assign bus.v_out_bin = v_out_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_bkm_steps_driver.sv
// Directed bench for bkm_steps_driver at WD=8, DPC=4, WC=8.
module tb_bkm_steps_driver;
  import bkm_csd_pkg::*;

  localparam int WD  = 8;
  localparam int WC  = 8;
  localparam int DPC = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       arst;
  logic       srst;
  logic       enable;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bkm_steps_driver_if #(.WD(WD), .WC(WC)) bus ();

  bkm_steps_driver #(.WD(WD), .WC(WC), .DPC(DPC)) dut (
    .clk       (clk),
    .arst      (arst),
    .srst      (srst),
    .enable    (enable),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- reference helpers ----------------
  function automatic logic [WD-1:0] csd2bin(input logic [2*WD-1:0] csd);
    logic [WD-1:0] acc;
    acc = '0;
    for (int i = 0; i < WD; i++) begin
      case (csd[2*i +: 2])
        2'b01:   acc = acc + (WD'(1) << i);
        2'b11:   acc = acc - (WD'(1) << i);
        default: ;
      endcase
    end
    return acc;
  endfunction

  function automatic bit csd_ok(input logic [2*WD-1:0] csd);
    for (int i = 0; i < WD; i++) begin
      if (csd[2*i +: 2] == 2'b10) return 1'b0;
      if (i > 0 && csd[2*i +: 2] != 2'b00 && csd[2*i-2 +: 2] != 2'b00) return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WD-1:0] x, input logic [WD-1:0] y,
                      input logic [WC-1:0] u, input logic [WC-1:0] v);
    int n;
    bus.X_in_bin = x;
    bus.Y_in_bin = y;
    bus.u_in_bin = u;
    bus.v_in_bin = v;
    bus.in_valid = 1'b1;
    n = 0;
    while (!(bus.in_ready && enable) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, required 1", bus.out_valid, lat);
    end
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_set(input string name, input logic [2*WD-1:0] ex,
                           input logic [2*WD-1:0] ey, input logic [WC-1:0] eu,
                           input logic [WC-1:0] ev);
    checks++;
    if (bus.X_in_csd !== ex || bus.Y_in_csd !== ey || bus.u_out_bin !== eu || bus.v_out_bin !== ev) begin
      errors++;
      $display("FAIL %s: got X=%h Y=%h u=%h v=%h, required X=%h Y=%h u=%h v=%h", name,
               bus.X_in_csd, bus.Y_in_csd, bus.u_out_bin, bus.v_out_bin, ex, ey, eu, ev);
    end
  endtask

  task automatic check_idle_reset(input string name);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || state_dbg !== 2'(IDLE) ||
        bus.X_in_csd !== '0 || bus.Y_in_csd !== '0 || bus.u_out_bin !== '0 || bus.v_out_bin !== '0) begin
      errors++;
      $display("FAIL %s: in_ready=%0b out_valid=%0b state=%0d X=%h Y=%h u=%h v=%h, required 1 0 0 and zero outputs",
               name, bus.in_ready, bus.out_valid, state_dbg, bus.X_in_csd, bus.Y_in_csd,
               bus.u_out_bin, bus.v_out_bin);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst = 1'b0;
    @(posedge clk); #1;
    check_idle_reset("reset_state");
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    send(8'h07, 8'h55, 8'hA5, 8'h3C);
    wait_out(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, required 4", lat);
    end
    check_set("basic_07_55", 16'h0043, 16'h1111, 8'hA5, 8'h3C);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL present_in_ready: got %0b, required 0", bus.in_ready);
    end
    take_out();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_xfer: in_ready=%0b out_valid=%0b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_negative();
    int lat;
    send(8'hFF, 8'h80, 8'h01, 8'hFE);
    wait_out(lat);
    check_set("neg_ff_80", 16'h0003, 16'hC000, 8'h01, 8'hFE);
    checks++;
    if (csd2bin(bus.Y_in_csd) !== 8'h80) begin
      errors++;
      $display("FAIL neg_roundtrip: got %h, required 80", csd2bin(bus.Y_in_csd));
    end
    take_out();
    send(8'h00, 8'h7F, 8'h00, 8'h7F);
    wait_out(lat);
    check_set("edge_00_7f", 16'h0000, 16'h4003, 8'h00, 8'h7F);
    take_out();
  endtask

  task automatic test_random();
    int lat;
    logic [WD-1:0] x, y;
    logic [WC-1:0] u, v;
    for (int k = 0; k < 3000; k++) begin
      x = WD'($urandom_range(0, 255));
      y = WD'($urandom_range(0, 255));
      u = WC'($urandom_range(0, 255));
      v = WC'($urandom_range(0, 255));
      send(x, y, u, v);
      wait_out(lat);
      checks++;
      if (csd2bin(bus.X_in_csd) !== x || csd2bin(bus.Y_in_csd) !== y ||
          !csd_ok(bus.X_in_csd) || !csd_ok(bus.Y_in_csd) ||
          bus.u_out_bin !== u || bus.v_out_bin !== v) begin
        errors++;
        $display("FAIL random_%0d: X=%h Y=%h u=%h v=%h for x=%h y=%h u=%h v=%h", k,
                 bus.X_in_csd, bus.Y_in_csd, bus.u_out_bin, bus.v_out_bin, x, y, u, v);
      end
      take_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit stable;
    send(8'h12, 8'h34, 8'h11, 8'h22);
    wait_out(lat);
    check_set("bp_12_34", 16'h0104, 16'h1310, 8'h11, 8'h22);
    // Offer a second set while the first is stuck in PRESENT.
    bus.X_in_bin = 8'h07;
    bus.Y_in_bin = 8'h55;
    bus.u_in_bin = 8'h33;
    bus.v_in_bin = 8'h44;
    bus.in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.X_in_csd !== 16'h0104 || bus.Y_in_csd !== 16'h1310) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: out_valid=%0b in_ready=%0b X=%h Y=%h, required 1 0 0104 1310",
               bus.out_valid, bus.in_ready, bus.X_in_csd, bus.Y_in_csd);
    end
    take_out();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_reready: in_ready=%0b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || state_dbg !== 2'(CONV_X)) begin
      errors++;
      $display("FAIL bp_second_accept: in_ready=%0b state=%0d, required 0 %0d", bus.in_ready, state_dbg, CONV_X);
    end
    wait_out(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL bp_second_latency: got %0d, required 4", lat);
    end
    check_set("bp_second", 16'h0043, 16'h1111, 8'h33, 8'h44);
    take_out();
  endtask

  task automatic test_reset_mid();
    int lat;
    // Asynchronous reset in CONV_Y.
    send(8'hFF, 8'h80, 8'h5A, 8'hA5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state_dbg !== 2'(CONV_Y)) begin
      errors++;
      $display("FAIL arst_setup_state: got %0d, required %0d", state_dbg, CONV_Y);
    end
    arst = 1'b0;
    #2;
    check_idle_reset("arst_mid_conv");
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk); #1;
    send(8'h07, 8'h55, 8'h01, 8'h02);
    wait_out(lat);
    check_set("arst_next", 16'h0043, 16'h1111, 8'h01, 8'h02);
    take_out();
    // Synchronous reset in CONV_X while carry is set by 0xFF.
    send(8'hFF, 8'hFF, 8'h03, 8'h04);
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    check_idle_reset("srst_mid_conv");
    send(8'h07, 8'h55, 8'h05, 8'h06);
    wait_out(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL srst_next_latency: got %0d, required 4", lat);
    end
    check_set("srst_next", 16'h0043, 16'h1111, 8'h05, 8'h06);
    take_out();
  endtask

  task automatic test_enable();
    int n_en;
    int iter;
    bit en_prev;
    send(8'h12, 8'h34, 8'h77, 8'h88);
    n_en = 0;
    iter = 0;
    while (!bus.out_valid && iter < 40) begin
      enable = iter[0];
      en_prev = enable;
      @(posedge clk); #1;
      if (en_prev) n_en++;
      iter++;
    end
    checks++;
    if (n_en != 4 || !bus.out_valid) begin
      errors++;
      $display("FAIL enable_latency: got %0d enabled cycles out_valid=%0b, required 4 and 1", n_en, bus.out_valid);
    end
    check_set("enable_result", 16'h0104, 16'h1310, 8'h77, 8'h88);
    // Frozen in PRESENT: out_ready high must not transfer.
    enable = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.X_in_csd !== 16'h0104) begin
      errors++;
      $display("FAIL enable_freeze: out_valid=%0b in_ready=%0b X=%h, required 1 0 0104",
               bus.out_valid, bus.in_ready, bus.X_in_csd);
    end
    enable = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL enable_release: out_valid=%0b in_ready=%0b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [WD-1:0]   xs [3] = '{8'h07, 8'h12, 8'h7F};
    logic [WD-1:0]   ys [3] = '{8'h55, 8'h34, 8'hFF};
    logic [2*WD-1:0] exs[3] = '{16'h0043, 16'h0104, 16'h4003};
    logic [2*WD-1:0] eys[3] = '{16'h1111, 16'h1310, 16'h0003};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(xs[k], ys[k], WC'(k), WC'(8'hF0 + k));
      wait_out(lat);
      check_set($sformatf("b2b_%0d", k), exs[k], eys[k], WC'(k), WC'(8'hF0 + k));
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_reready_%0d: in_ready=%0b out_valid=%0b, required 1 0", k, bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    arst          = 1'b0;
    srst          = 1'b0;
    enable        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.X_in_bin  = '0;
    bus.Y_in_bin  = '0;
    bus.u_in_bin  = '0;
    bus.v_in_bin  = '0;
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_reset_mid();
    test_enable();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
